// File: rtl/cc_display_pkg.sv
// cc_display_pkg
// Constants and types shared by the binary-to-BCD converter and the
// four-digit seven-segment display path.
//   DIGIT_W    : bits per decimal digit
//   NUM_DIGITS : digits on the display
//   BCD_DASH   : digit code the display decoder renders as '-'
//   MAX_DEC    : largest value that fits on four decimal digits
//   state_t    : converter FSM states
package cc_display_pkg;

  localparam int          DIGIT_W    = 4;
  localparam int          NUM_DIGITS = 4;
  localparam logic [3:0]  BCD_DASH   = 4'hF;
  localparam int unsigned MAX_DEC    = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/cc_bcd_adj3.sv
// cc_bcd_adj3
// Combinational digit adjust for the shift-add-3 algorithm: a nibble of 5 or
// more gets 3 added, so that the following left shift carries into the next
// decimal digit exactly when the digit reaches 10.
//   nibble   in  4  BCD scratch digit before the shift
//   adjusted out 4  digit after the conditional +3
module cc_bcd_adj3 (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = nibble;
    if (nibble >= 4'd5) begin
      adjusted = nibble + 4'd3;
    end
  end

endmodule

// File: rtl/cc_bin2bcd_seq.sv
// cc_bin2bcd_seq
// Sequential binary-to-BCD converter, one binary bit per clock, feeding the
// four-digit seven-segment multiplexer. Values above 9999 are shown as "----".
//   CC_BIN2BCD_CLOCK_50    in  1     system clock, rising edge
//   CC_BIN2BCD_RESET_InLow in  1     asynchronous active-low reset
//   CC_BIN2BCD_start       in  1     conversion request, honoured only in IDLE
//   CC_BIN2BCD_bin         in  IN_W  unsigned value, captured with start
//   CC_BIN2BCD_busy        out 1     high in SHIFT and DONE
//   CC_BIN2BCD_done        out 1     one-cycle pulse, new digits valid with it
//   CC_BIN2BCD_ovf         out 1     last value exceeded 9999
//   CC_BIN2BCD_bcd0..bcd3  out 4     units .. thousands digits (registered)
module cc_bin2bcd_seq
  import cc_display_pkg::*;
#(
  parameter int IN_W = 14
) (
  input  logic            CC_BIN2BCD_CLOCK_50,
  input  logic            CC_BIN2BCD_RESET_InLow,
  input  logic            CC_BIN2BCD_start,
  input  logic [IN_W-1:0] CC_BIN2BCD_bin,
  output logic            CC_BIN2BCD_busy,
  output logic            CC_BIN2BCD_done,
  output logic            CC_BIN2BCD_ovf,
  output logic [3:0]      CC_BIN2BCD_bcd0,
  output logic [3:0]      CC_BIN2BCD_bcd1,
  output logic [3:0]      CC_BIN2BCD_bcd2,
  output logic [3:0]      CC_BIN2BCD_bcd3
);

  localparam int SCR_W = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(IN_W);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [IN_W-1:0]   bin_reg;
  logic [SCR_W-1:0]  scr_reg;
  logic              ovf_pending_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              ovf_reg;
  logic [SCR_W-1:0]  bcd_reg;

  logic [SCR_W-1:0]  scr_adj;
  logic [SCR_W-1:0]  scr_next;
  logic [31:0]       bin_ext;

  // Digit adjust on every scratch nibble before the shift.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      cc_bcd_adj3 u_adj (
        .nibble   (scr_reg[gi*DIGIT_W +: DIGIT_W]),
        .adjusted (scr_adj[gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // Left shift of {scratch, binary}; the MSB of the adjusted scratch falls
  // off, which only happens for values that will be dashed anyway.
  assign scr_next = {scr_adj[SCR_W-2:0], bin_reg[IN_W-1]};
  assign bin_ext  = 32'(CC_BIN2BCD_bin);

  always_ff @(posedge CC_BIN2BCD_CLOCK_50 or negedge CC_BIN2BCD_RESET_InLow) begin
    if (!CC_BIN2BCD_RESET_InLow) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      bin_reg         <= '0;
      scr_reg         <= '0;
      ovf_pending_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      ovf_reg         <= 1'b0;
      bcd_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (CC_BIN2BCD_start) begin
            bin_reg         <= CC_BIN2BCD_bin;
            scr_reg         <= '0;
            cnt_reg         <= CNT_W'(IN_W - 1);
            ovf_pending_reg <= (bin_ext > MAX_DEC);
            busy_reg        <= 1'b1;
            state_reg       <= SHIFT;
          end
        end

        SHIFT: begin
          scr_reg <= scr_next;
          bin_reg <= {bin_reg[IN_W-2:0], 1'b0};
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            // Output registers move only here, so the display never sees
            // intermediate scratch values.
            state_reg <= DONE;
            done_reg  <= 1'b1;
            ovf_reg   <= ovf_pending_reg;
            bcd_reg   <= ovf_pending_reg ? {NUM_DIGITS{BCD_DASH}} : scr_next;
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign CC_BIN2BCD_busy = busy_reg;
  assign CC_BIN2BCD_done = done_reg;
  assign CC_BIN2BCD_ovf  = ovf_reg;
  assign CC_BIN2BCD_bcd0 = bcd_reg[3:0];
  assign CC_BIN2BCD_bcd1 = bcd_reg[7:4];
  assign CC_BIN2BCD_bcd2 = bcd_reg[11:8];
  assign CC_BIN2BCD_bcd3 = bcd_reg[15:12];

endmodule

// File: tb/tb_cc_bin2bcd_seq.sv
// Testbench for cc_bin2bcd_seq: driver pushes expected results into a
// scoreboard queue, a monitor pops and compares on every done pulse.
module tb_cc_bin2bcd_seq;

  localparam int IN_W = 14;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [IN_W-1:0] bin;
  logic            busy, done, ovf;
  logic [3:0]      bcd0, bcd1, bcd2, bcd3;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int unsigned start_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          n_vec;
  int          n_err;
  logic [16:0] prev_out;

  cc_bin2bcd_seq #(.IN_W(IN_W)) dut (
    .CC_BIN2BCD_CLOCK_50    (clk),
    .CC_BIN2BCD_RESET_InLow (rst_n),
    .CC_BIN2BCD_start       (start),
    .CC_BIN2BCD_bin         (bin),
    .CC_BIN2BCD_busy        (busy),
    .CC_BIN2BCD_done        (done),
    .CC_BIN2BCD_ovf         (ovf),
    .CC_BIN2BCD_bcd0        (bcd0),
    .CC_BIN2BCD_bcd1        (bcd1),
    .CC_BIN2BCD_bcd2        (bcd2),
    .CC_BIN2BCD_bcd3        (bcd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal reference built by division; dashes above 9999.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    if (v > 9999) return 16'hFFFF;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Monitor: compare on done, and flag any output change without done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("digits", {16'd0, bcd3, bcd2, bcd1, bcd0}, {16'd0, e.bcd});
          check("ovf", 32'(ovf), 32'(e.ovf));
          check("latency", cyc, e.start_cyc + IN_W + 1);
          if (!ovf) begin
            check("digit_range",
                  32'((bcd0 > 4'd9) || (bcd1 > 4'd9) || (bcd2 > 4'd9) || (bcd3 > 4'd9)),
                  32'd0);
          end
          $display("done: bcd=%h%h%h%h ovf=%0d", bcd3, bcd2, bcd1, bcd0, ovf);
        end
      end else if ({ovf, bcd3, bcd2, bcd1, bcd0} !== prev_out) begin
        check("hold_outputs", {15'd0, ovf, bcd3, bcd2, bcd1, bcd0}, {15'd0, prev_out});
      end
    end
    prev_out = {ovf, bcd3, bcd2, bcd1, bcd0};
  end

  // Called at a negedge; returns at a negedge with busy low (or flags timeout).
  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic send(input logic [IN_W-1:0] v, input logic [15:0] eb, input logic eo);
    wait_idle();
    bin   = v;
    start = 1'b1;
    sb.push_back('{eb, eo, cyc});
    $display("start: bin=%0d", v);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int unsigned last_cyc;
    int          busy_cnt;
    bit          saw_done;

    n_vec    = 0;
    n_err    = 0;
    start    = 1'b0;
    bin      = '0;
    prev_out = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out", {15'd0, ovf, bcd3, bcd2, bcd1, bcd0}, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 1234: latency and busy width.
    bin   = 14'd1234;
    start = 1'b1;
    sb.push_back('{16'h1234, 1'b0, cyc});
    $display("start: bin=1234");
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
    end
    check("busy_cycles", 32'(busy_cnt), 32'd15);

    // Boundary and directed values.
    send(14'd0,     16'h0000, 1'b0);
    send(14'd9999,  16'h9999, 1'b0);
    send(14'd10000, 16'hFFFF, 1'b1);
    send(14'd16383, 16'hFFFF, 1'b1);
    send(14'd5,     16'h0005, 1'b0);
    send(14'd59,    16'h0059, 1'b0);
    send(14'd1000,  16'h1000, 1'b0);
    send(14'd8421,  16'h8421, 1'b0);

    // Reset mid-conversion: outputs clear at once, no done follows.
    bin   = 14'd1234;
    start = 1'b1;
    sb.push_back('{16'h1234, 1'b0, cyc});
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", {15'd0, ovf, bcd3, bcd2, bcd1, bcd0}, 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("no_done_after_reset", 32'(saw_done), 32'd0);
    send(14'd1234, 16'h1234, 1'b0);

    // Start re-pulsed mid-conversion is ignored.
    bin   = 14'd777;
    start = 1'b1;
    sb.push_back('{16'h0777, 1'b0, cyc});
    $display("start: bin=777 (with ignored start bin=42)");
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bin   = 14'd42;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = 14'd0;
    wait_idle();
    repeat (20) @(negedge clk);
    check("hold_0777", {15'd0, ovf, bcd3, bcd2, bcd1, bcd0}, 32'h0_0777);
    check("ignored_start_no_queue", 32'(busy), 32'd0);

    // Start held high: back-to-back every IN_W+2 cycles.
    start    = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      wait_idle();
      bin = 14'(i);
      sb.push_back('{ref_bcd(i), 1'b0, cyc});
      if (i > 0) check("b2b_spacing", cyc - last_cyc, 32'(IN_W + 2));
      last_cyc = cyc;
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Strided sweep against the division model.
    for (int v = 0; v < 16384; v += 97) begin
      send(14'(v), ref_bcd(v), 1'(v > 9999));
    end
    send(14'd16383, ref_bcd(16383), 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
